// File: rtl/series_accumulator_if.sv
// Term-in / result-out bundle between the Taylor term generator, the series
// accumulator and the consumer of the finished sum.
interface series_accumulator_if #(
    parameter int WIDTH = 16
);
    logic             start;
    logic [1:0]       func;
    logic [WIDTH-1:0] term;
    logic             term_valid;
    logic             last;
    logic [WIDTH-1:0] result;
    logic             result_valid;
    logic             result_ready;
    logic             busy;

    // result moves on the first rising edge with result_valid && result_ready.
    // result_valid never waits on result_ready, and result is held until then.
    // Terms have no backpressure: every term_valid strobe is taken.
    modport master (
        output start, func, term, term_valid, last, result_ready,
        input  result, result_valid, busy
    );

    modport slave (
        input  start, func, term, term_valid, last, result_ready,
        output result, result_valid, busy
    );
endinterface

// File: rtl/series_accumulator.sv
// Signed series accumulator behind the Taylor term generator: applies the
// per-function sign/selection rule to each term and saturates the final sum.
module series_accumulator #(
    parameter int WIDTH = 16,
    parameter int FRAC  = 12,
    parameter int GUARD = 4
) (
    input  logic                 clk,
    input  logic                 rst,
    series_accumulator_if.slave  bus,
    output logic [1:0]           dbg_state
);
    localparam int ACC_W = WIDTH + GUARD;
    localparam logic signed [ACC_W-1:0] ONE   = ACC_W'(1) << FRAC;
    localparam logic signed [ACC_W-1:0] MAX_V = {{(GUARD+1){1'b0}}, {(WIDTH-1){1'b1}}};
    localparam logic signed [ACC_W-1:0] MIN_V = {{(GUARD+1){1'b1}}, {(WIDTH-1){1'b0}}};

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ACCUM = 2'd1,
        DONE  = 2'd2
    } state_t;

    state_t                  state;
    logic [1:0]              func_q;
    logic signed [ACC_W-1:0] acc;
    logic [4:0]              k;

    logic signed [ACC_W-1:0] term_ext;
    logic signed [ACC_W-1:0] sum_next;
    logic [WIDTH-1:0]        sat;
    logic                    do_add;
    logic                    do_sub;

    assign dbg_state = state;
    assign term_ext  = {{GUARD{bus.term[WIDTH-1]}}, bus.term};

    // k[0] picks odd/even terms, k[1] separates k mod 4 = 1/3 and 2/0.
    always_comb begin
        do_add = 1'b0;
        do_sub = 1'b0;
        case (func_q)
            2'd0: do_add = 1'b1;
            2'd1: if (k[0]) begin
                do_add = ~k[1];
                do_sub = k[1];
            end
            2'd2: if (!k[0]) begin
                do_add = ~k[1];
                do_sub = k[1];
            end
            default: begin
                do_add = k[0];
                do_sub = ~k[0];
            end
        endcase
    end

    always_comb begin
        sum_next = acc;
        if (do_add)
            sum_next = acc + term_ext;
        else if (do_sub)
            sum_next = acc - term_ext;
    end

    always_comb begin
        sat = sum_next[WIDTH-1:0];
        if (sum_next > MAX_V)
            sat = MAX_V[WIDTH-1:0];
        else if (sum_next < MIN_V)
            sat = MIN_V[WIDTH-1:0];
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state            <= IDLE;
            func_q           <= 2'd0;
            acc              <= '0;
            k                <= 5'd0;
            bus.result       <= '0;
            bus.result_valid <= 1'b0;
            bus.busy         <= 1'b0;
        end else begin
            case (state)
                IDLE: if (bus.start) begin
                    func_q   <= bus.func;
                    acc      <= (bus.func == 2'd0 || bus.func == 2'd2) ? ONE : '0;
                    k        <= 5'd1;
                    bus.busy <= 1'b1;
                    state    <= ACCUM;
                end
                ACCUM: if (bus.term_valid) begin
                    acc <= sum_next;
                    if (k != 5'd31)
                        k <= k + 5'd1;
                    if (bus.last) begin
                        bus.result       <= sat;
                        bus.result_valid <= 1'b1;
                        state            <= DONE;
                    end
                end
                DONE: if (bus.result_ready) begin
                    bus.result_valid <= 1'b0;
                    bus.busy         <= 1'b0;
                    state            <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_series_accumulator.sv
// Directed bench for series_accumulator: one run per function, saturation,
// output handshake stalls and asynchronous reset mid-evaluation.
module tb_series_accumulator;
    logic       clk;
    logic       rst;
    logic [1:0] dbg_state;
    int         total;
    int         bad;
    logic [15:0] exp_q[$];

    series_accumulator_if #(.WIDTH(16)) bus ();

    series_accumulator #(.WIDTH(16), .FRAC(12), .GUARD(4)) dut (
        .clk       (clk),
        .rst       (rst),
        .bus       (bus),
        .dbg_state (dbg_state)
    );

    // clock / reset
    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: time limit reached, total=%0d bad=%0d", total, bad);
        $fatal(1);
    end

    task automatic check(input string tag, input int obs, input int exp);
        total++;
        if (obs !== exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
        end
    endtask

    // driver tasks
    task automatic begin_eval(input logic [1:0] f);
        @(negedge clk);
        bus.start = 1'b1;
        bus.func  = f;
        @(negedge clk);
        bus.start = 1'b0;
        check("busy_after_start", int'(bus.busy), 1);
    endtask

    task automatic send_term(input int v, input logic l, input int gap);
        @(negedge clk);
        bus.term       = 16'(v);
        bus.term_valid = 1'b1;
        bus.last       = l;
        @(negedge clk);
        bus.term_valid = 1'b0;
        bus.last       = 1'b0;
        if (l)
            check("valid_after_last", int'(bus.result_valid), 1);
        repeat (gap) @(negedge clk);
    endtask

    // scoreboard: compare result with the head of exp_q, then hand it off
    task automatic collect(input string tag);
        logic [15:0] e;
        for (int i = 0; i < 20 && !bus.result_valid; i++)
            @(negedge clk);
        check({tag, "_valid"}, int'(bus.result_valid), 1);
        e = exp_q.pop_front();
        check({tag, "_result"}, int'($signed(bus.result)), int'($signed(e)));
        bus.result_ready = 1'b1;
        @(negedge clk);
        bus.result_ready = 1'b0;
        check({tag, "_valid_drop"}, int'(bus.result_valid), 0);
        check({tag, "_busy_drop"}, int'(bus.busy), 0);
    endtask

    task automatic run_exp_basic(input string tag);
        begin_eval(2'd0);
        send_term(4096, 1'b0, 2);
        check({tag, "_busy_mid"}, int'(bus.busy), 1);
        send_term(2048, 1'b0, 2);
        send_term(683, 1'b1, 0);
        exp_q.push_back(16'd10923);
        collect(tag);
    endtask

    initial begin
        int sv[7];
        total            = 0;
        bad              = 0;
        rst              = 1'b1;
        bus.start        = 1'b0;
        bus.func         = 2'd0;
        bus.term         = '0;
        bus.term_valid   = 1'b0;
        bus.last         = 1'b0;
        bus.result_ready = 1'b0;
        repeat (3) @(negedge clk);
        check("rst_result", int'(bus.result), 0);
        check("rst_valid", int'(bus.result_valid), 0);
        check("rst_busy", int'(bus.busy), 0);
        check("rst_state", int'(dbg_state), 0);
        rst = 1'b0;

        // stray term in IDLE must not disturb the next run
        send_term(1000, 1'b0, 1);
        check("idle_term_busy", int'(bus.busy), 0);
        run_exp_basic("exp");

        begin_eval(2'd1);
        send_term(4096, 1'b0, 2);
        send_term(2048, 1'b0, 2);
        send_term(683, 1'b0, 2);
        send_term(171, 1'b1, 0);
        exp_q.push_back(16'd3413);
        collect("sin");

        begin_eval(2'd2);
        send_term(4096, 1'b0, 2);
        send_term(2048, 1'b0, 2);
        send_term(683, 1'b0, 2);
        send_term(171, 1'b1, 0);
        exp_q.push_back(16'd2219);
        collect("cos");

        // ready raised before the result exists
        begin_eval(2'd3);
        bus.result_ready = 1'b1;
        send_term(4096, 1'b0, 2);
        send_term(2048, 1'b0, 2);
        send_term(1365, 1'b1, 0);
        exp_q.push_back(16'd3413);
        collect("ln");

        // back-to-back strobes, positive saturation
        begin_eval(2'd0);
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            bus.term       = 16'd32767;
            bus.term_valid = 1'b1;
            bus.last       = (i == 9);
        end
        @(negedge clk);
        bus.term_valid = 1'b0;
        bus.last       = 1'b0;
        exp_q.push_back(16'd32767);
        collect("exp_sat");

        // back-to-back strobes, negative saturation
        sv = '{0, 0, 32767, 0, 0, 0, 32767};
        begin_eval(2'd1);
        for (int i = 0; i < 7; i++) begin
            @(negedge clk);
            bus.term       = 16'(sv[i]);
            bus.term_valid = 1'b1;
            bus.last       = (i == 6);
        end
        @(negedge clk);
        bus.term_valid = 1'b0;
        bus.last       = 1'b0;
        exp_q.push_back(16'h8000);
        collect("sin_sat");

        // stall in DONE with a stray start pulse and stray term
        begin_eval(2'd0);
        send_term(4096, 1'b0, 2);
        send_term(2048, 1'b0, 2);
        send_term(683, 1'b1, 0);
        for (int i = 0; i < 5; i++) begin
            bus.start      = (i == 2);
            bus.term_valid = (i == 3);
            bus.term       = 16'd500;
            @(negedge clk);
            check("stall_valid", int'(bus.result_valid), 1);
            check("stall_result", int'(bus.result), 10923);
        end
        bus.start      = 1'b0;
        bus.term_valid = 1'b0;
        check("stall_state", int'(dbg_state), 2);
        exp_q.push_back(16'd10923);
        collect("stall");
        @(negedge clk);
        check("no_restart_busy", int'(bus.busy), 0);

        // asynchronous reset mid-evaluation
        begin_eval(2'd0);
        send_term(4096, 1'b0, 0);
        #2 rst = 1'b1;
        #1;
        check("arst_result", int'(bus.result), 0);
        check("arst_valid", int'(bus.result_valid), 0);
        check("arst_busy", int'(bus.busy), 0);
        check("arst_state", int'(dbg_state), 0);
        @(negedge clk);
        rst = 1'b0;
        run_exp_basic("exp_after_rst");

        // final report
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/series_accumulator.md
# series_accumulator

Downstream stage of the Taylor-series term generator used by the sin/cos/exp/ln units. It consumes one term per upstream `Done` pulse, applies the function-specific sign and term-selection rule, and sums into a wide fixed-point accumulator. On the upstream last-term flag (`co`) it saturates the sum to `WIDTH` bits and presents it on a valid/ready output handshake.

## Interface
- `WIDTH`, 16: signed fixed-point width of `term` and `result`.
- `FRAC`, 12: fractional bits; 1.0 = 2^FRAC.
- `GUARD`, 4: extra accumulator integer bits; ACC_W = WIDTH+GUARD.

- `clk` input 1: clock, rising edge.
- `rst` input 1: reset. Asynchronous and active-high; one clock domain.
- `start` input 1: begin a new evaluation; sampled only in IDLE.
- `func` input 2: function code, captured at start. 0 = exp, 1 = sin, 2 = cos, 3 = ln(1+x).
- `term` input WIDTH: signed k-th term magnitude from upstream (x^k/k! or x^k/k).
- `term_valid` input 1: one-cycle strobe, driven by upstream `Done`.
- `last` input 1: qualifies `term_valid` as the final term, driven by upstream `co`.
- `result` output WIDTH: saturated signed sum.
- `result_valid` output 1: result available.
- `result_ready` input 1: consumer accepts result.
- `busy` output 1: high in ACCUM and DONE.

## Operation
- State machine: IDLE, ACCUM, DONE.
- **IDLE**
  - On `start`: capture `func`, load `acc` with its initial value, set `k` = 1, go to ACCUM.
  - Initial `acc`: 2^FRAC for exp and cos; 0 for sin and ln.
  - `term_valid` is ignored in IDLE.
- **ACCUM**
  - On `term_valid`, sign-extend `term` to ACC_W, then add, subtract or skip according to `func` and `k`:
    - exp: add every term.
    - sin: odd `k` only; add if k mod 4 = 1, subtract if k mod 4 = 3.
    - cos: even `k` only; subtract if k mod 4 = 2, add if k mod 4 = 0.
    - ln: add if `k` is odd, subtract if `k` is even.
  - Skipped terms still increment `k`.
  - `k` is 5 bits and saturates at 31; it never wraps.
  - `term_valid` with `last` = 1: perform the update, register the saturated result, go to DONE.
  - `start` is ignored in ACCUM and DONE.
- **DONE**
  - `result_valid` = 1; `result` is held stable.
  - When `result_valid` and `result_ready` are both high, go to IDLE; `result_valid` drops the next cycle.
  - `term_valid` is ignored in DONE.
- Arithmetic
  - Two's complement at ACC_W bits; no internal overflow is expected within GUARD.
  - `result` clamps to [-2^(WIDTH-1), 2^(WIDTH-1)-1].
  - Saturation is computed on the post-update sum, i.e. including the last term.
- Reset, from any state including mid-evaluation:
  - State → IDLE.
  - `acc`, `k`, `result` = 0.
  - `result_valid` = 0, `busy` = 0.

## Timing
- Reset values: `result` = 0, `result_valid` = 0, `busy` = 0.
- Start: `start` high in IDLE at edge n → `busy` high from edge n.
- Terms: each term is accepted at the edge where `term_valid` is high. There is no backpressure on terms; upstream spaces them at least 3 cycles apart, but the block must accept back-to-back strobes.
- Latency: last term at edge n → `result`/`result_valid` valid after edge n (one register stage).
- Output handshake: `result_ready` may be high before `result_valid`. The transfer occurs on the first edge where both are high.
- Back-to-back evaluations: `start` is honoured in the first IDLE cycle after the handshake.

## Test plan
Settings: WIDTH = 16, FRAC = 12, so 1.0 = 4096.

1. **exp:** `start`, `func` = 0; terms 4096, 2048, 683 with `last` on the third → `result` = 10923 and `result_valid` one cycle after the last term; `busy` high throughout.
2. **sin:** `func` = 1; terms 4096, 2048, 683, 171 with `last` on the fourth → `result` = 3413 (4096 − 683).
3. **cos:** `func` = 2; same terms as scenario 2 → `result` = 2219 (4096 − 2048 + 171).
4. **ln:** `func` = 3; terms 4096, 2048, 1365 → `result` = 3413.
5. **Saturation:**
   - exp with 10 terms of 32767 → `result` = 32767.
   - sin with terms 0, 0, 32767, 0, 0, 0, 32767 → `result` = −32768.
   - Back-to-back `term_valid` strobes are all accumulated.
6. **Handshake and reset:**
   - Hold `result_ready` low 5 cycles in DONE → `result` and `result_valid` stable; a `start` pulse during DONE is ignored.
   - Release `result_ready` → IDLE.
   - Assert `rst` mid-ACCUM → all outputs 0 immediately; a following exp run (scenario 1) returns 10923.
